// File: rtl/fetch_pkg.sv
// Types and constants shared by the instruction fetch front end.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    S_RESET = 1'b0,
    S_RUN   = 1'b1
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/defines.svh
// Shared bus widths and chip-enable encodings for the instruction ROM interface.
`ifndef DEFINES_SVH
`define DEFINES_SVH

`define InstAddrBus 31:0
`define InstBus     31:0
`define ChipEnable  1'b1
`define ChipDisable 1'b0

`endif

// File: rtl/fetch_queue.sv
// In-order fetch queue: small register-based FIFO with flush and push-while-full-and-popping.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic          push_ok, pop_ok;
  fetch_entry_t  mem_reg [QDEPTH];

  // Extra pointer bit separates full from empty when the index bits match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok) && !flush;
  assign head    = mem_reg[rd_ptr_reg[AW-1:0]];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push_ok) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (pop_ok)  rd_ptr_next = rd_ptr_reg + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < QDEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push_ok && (wr_ptr_reg[AW-1:0] == AW'(gi))) mem_reg[gi] <= push_data;
      end
    end
  endgenerate

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the PC, drives the combinational ROM and feeds decode in order.
`include "defines.svh"

module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                rom_ce,
  output logic [`InstAddrBus] rom_addr,
  input  logic [`InstBus]     rom_inst,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_pc,
  output logic [31:0]         out_inst
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         fetch_go;
  logic         pop;
  logic         q_empty, q_full;
  fetch_entry_t push_entry, head_entry;

  assign pop        = out_valid && out_ready;
  assign push_entry = '{pc: pc_reg, inst: rom_inst};

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    fetch_go   = 1'b0;
    case (state_reg)
      S_RESET: state_next = S_RUN;
      S_RUN: begin
        state_next = S_RUN;
        // A pop frees the slot this cycle, so fetch may continue even when full.
        fetch_go   = !redirect_valid && (!q_full || pop);
      end
      default: state_next = S_RESET;
    endcase
    if (redirect_valid) pc_next = {redirect_pc[31:2], 2'b00};
    else if (fetch_go)  pc_next = pc_reg + PC_STEP;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_RESET;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  fetch_queue #(
    .QDEPTH(QDEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (fetch_go),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head_entry),
    .empty    (q_empty),
    .full     (q_full)
  );

  assign rom_ce    = fetch_go ? `ChipEnable : `ChipDisable;
  assign rom_addr  = pc_reg;
  assign out_valid = !q_empty;
  assign out_pc    = head_entry.pc;
  assign out_inst  = head_entry.inst;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: queue-based reference model plus directed literal checks.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  assign rom_inst = rom_word(rom_addr);

  inst_fetch #(
    .RESET_PC(RESET_PC),
    .QDEPTH  (QDEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rom_ce        (rom_ce),
    .rom_addr      (rom_addr),
    .rom_inst      (rom_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  bit          m_run;
  int          checks = 0;
  int          errors = 0;
  logic        s_valid, s_ce;
  logic [31:0] s_pc, s_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, compare against the model, then advance the model at the edge.
  task automatic cycle(input logic rn, input logic rv, input logic [31:0] rpc, input logic rdy);
    bit exp_valid, hs, exp_go;
    rst_n          = rn;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    exp_valid = (mq.size() != 0);
    hs        = exp_valid && rdy;
    exp_go    = m_run && !rv && ((mq.size() < QDEPTH) || hs);
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    chk("rom_ce", {31'b0, rom_ce}, {31'b0, exp_go});
    chk("rom_addr", rom_addr, m_pc);
    if (exp_valid) begin
      chk("out_pc", out_pc, mq[0].pc);
      chk("out_inst", out_inst, mq[0].inst);
    end
    s_valid = out_valid;
    s_ce    = rom_ce;
    s_pc    = out_pc;
    s_addr  = rom_addr;
    if (hs && rn && !rv) $display("pop pc=%h inst=%h", out_pc, out_inst);
    @(posedge clk);
    if (!rn) begin
      mq.delete();
      m_pc  = RESET_PC;
      m_run = 1'b0;
    end else if (rv) begin
      mq.delete();
      m_pc  = {rpc[31:2], 2'b00};
      m_run = 1'b1;
    end else begin
      if (hs) void'(mq.pop_front());
      if (exp_go) begin
        mq.push_back('{pc: m_pc, inst: rom_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      m_run = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic        r_rn, r_rv, r_rdy;
    logic [31:0] r_pc;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mq.delete();
    m_pc  = RESET_PC;
    m_run = 1'b0;

    // Reset and streaming
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("reset_valid", {31'b0, s_valid}, 32'd0);
    chk("reset_addr", s_addr, RESET_PC);
    cycle(1, 0, 0, 1);
    chk("first_cycle_ce_off", {31'b0, s_ce}, 32'd0);
    cycle(1, 0, 0, 1);
    chk("first_ce_on", {31'b0, s_ce}, 32'd1);
    chk("first_addr", s_addr, RESET_PC);
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, 0, 1);
      chk("stream_valid", {31'b0, s_valid}, 32'd1);
      chk("stream_pc", s_pc, RESET_PC + 32'(4 * k));
    end

    // Backpressure after a fresh reset
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) cycle(1, 0, 0, 0);
    chk("bp_ce_off", {31'b0, s_ce}, 32'd0);
    chk("bp_addr_hold", s_addr, 32'h8);
    chk("bp_head", s_pc, 32'h0);
    for (int k = 0; k < 3; k++) begin
      cycle(1, 0, 0, 1);
      chk("bp_release_pc", s_pc, 32'(4 * k));
    end

    // Full queue with simultaneous push and pop
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, 0, 1);
      chk("full_pushpop_ce", {31'b0, s_ce}, 32'd1);
      chk("full_pushpop_pc", s_pc, 32'(12 + 4 * k));
    end

    // Redirect with entries queued
    cycle(1, 1, 32'h0000_1003, 1);
    cycle(1, 0, 0, 1);
    chk("redir_valid", {31'b0, s_valid}, 32'd0);
    chk("redir_addr", s_addr, 32'h0000_1000);
    chk("redir_ce", {31'b0, s_ce}, 32'd1);
    cycle(1, 0, 0, 1);
    chk("redir_pc0", s_pc, 32'h0000_1000);
    cycle(1, 0, 0, 1);
    chk("redir_pc1", s_pc, 32'h0000_1004);

    // Address wrap
    cycle(1, 1, 32'hFFFF_FFF8, 1);
    cycle(1, 0, 0, 1);
    chk("wrap_addr", s_addr, 32'hFFFF_FFF8);
    cycle(1, 0, 0, 1);
    chk("wrap_pc0", s_pc, 32'hFFFF_FFF8);
    cycle(1, 0, 0, 1);
    chk("wrap_pc1", s_pc, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 1);
    chk("wrap_pc2", s_pc, 32'h0000_0000);

    // Mid-run reset while full
    for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 1);
    chk("midrst_valid", {31'b0, s_valid}, 32'd0);
    chk("midrst_addr", s_addr, RESET_PC);
    chk("midrst_ce", {31'b0, s_ce}, 32'd0);
    cycle(1, 0, 0, 1);
    chk("midrst_restart_ce", {31'b0, s_ce}, 32'd1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r_rn  = ($urandom_range(0, 63) != 0);
      r_rv  = ($urandom_range(0, 7) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_pc  = $urandom();
      if ($urandom_range(0, 3) == 0) r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hF);
      cycle(r_rn, r_rv, r_pc, r_rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
